wb_merge_unit: RTL and testbench

- Collects writeback results from the execute-stage functional units: fixed-latency, load, store, FPU and CV-X-IF.
- Funnels them into a smaller number of scoreboard writeback ports.
- Each source has its own small FIFO and a valid/ready handshake. Buffered results are granted to the writeback ports round-robin.
- Sits between the execute stage and the scoreboard. It lets FUs complete in the same cycle without port collisions.

---
 rtl/wb_merge_unit_pkg.sv | 36 +++
 rtl/wb_rr_select.sv | 53 +++++
 rtl/wb_merge_unit.sv | 128 ++++++++++++
 tb/tb_wb_merge_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_merge_unit_pkg.sv
// Shared types and constants for the writeback merge unit.
//   XLEN / TRANS_ID_BITS : datapath and scoreboard-id widths
//   exception_t          : exception record carried with every result
//   wb_entry_t           : one buffered writeback {trans_id, result, exception}
//   WB_SRC_*             : source index of each execute-stage functional unit
package wb_merge_unit_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned TRANS_ID_BITS = 4;
  localparam int unsigned NR_WB_PORTS   = 2;
  localparam int unsigned WB_NR_SRC     = 5;

  localparam int unsigned WB_SRC_FLU    = 0;
  localparam int unsigned WB_SRC_LOAD   = 1;
  localparam int unsigned WB_SRC_STORE  = 2;
  localparam int unsigned WB_SRC_FPU    = 3;
  localparam int unsigned WB_SRC_CVXIF  = 4;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          result;
    exception_t               ex;
  } wb_entry_t;

  // Width of an index into n items; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/wb_rr_select.sv
// Round-robin selection of up to NR_WB non-empty sources (combinational).
//   nonempty_i    : per-source "FIFO has an entry"
//   rr_i          : source index where the circular scan starts
//   grant_idx_o   : source index granted to each writeback port
//   grant_valid_o : writeback port carries a grant
//   pop_o         : per-source pop mask (one pop per granted source)
//   rr_next_o     : one past the last granted source, or rr_i if none
module wb_rr_select
  import wb_merge_unit_pkg::*;
#(
  parameter int unsigned NR_SRC = 5,
  parameter int unsigned NR_WB  = 2,
  localparam int unsigned IDX_W = idx_width(NR_SRC),
  localparam int unsigned WB_W  = idx_width(NR_WB)
) (
  input  logic [NR_SRC-1:0]           nonempty_i,
  input  logic [IDX_W-1:0]            rr_i,
  output logic [NR_WB-1:0][IDX_W-1:0] grant_idx_o,
  output logic [NR_WB-1:0]            grant_valid_o,
  output logic [NR_SRC-1:0]           pop_o,
  output logic [IDX_W-1:0]            rr_next_o
);

  // Circular scan from rr_i; the k-th non-empty source found goes to port k.
  always_comb begin : scan_p
    int unsigned cnt;
    int unsigned idx;
    cnt           = 32'd0;
    idx           = 32'd0;
    grant_idx_o   = '0;
    grant_valid_o = '0;
    pop_o         = '0;
    rr_next_o     = rr_i;
    for (int unsigned off = 0; off < NR_SRC; off++) begin
      idx = 32'(rr_i) + off;
      if (idx >= NR_SRC) begin
        idx = idx - NR_SRC;
      end else begin
        idx = idx;
      end
      if (nonempty_i[IDX_W'(idx)] && (cnt < NR_WB)) begin
        grant_idx_o[WB_W'(cnt)]   = IDX_W'(idx);
        grant_valid_o[WB_W'(cnt)] = 1'b1;
        pop_o[IDX_W'(idx)]        = 1'b1;
        rr_next_o = (idx == NR_SRC - 32'd1) ? '0 : IDX_W'(idx + 32'd1);
        cnt = cnt + 32'd1;
      end else begin
        cnt = cnt;
      end
    end
  end

endmodule

// File: rtl/wb_merge_unit.sv
// Writeback merge unit: buffers results from NR_SRC execute-stage sources in
// per-source FIFOs and drains them round-robin onto NR_WB scoreboard ports.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   flush_i          : discard all buffered results, restart arbitration at 0
//   src_*_i/o        : per-source valid/ready push interface
//   wb_*_o           : writeback ports (always accepted by the scoreboard)
//   overflow_o       : sticky, a source pushed while its FIFO was full
module wb_merge_unit
  import wb_merge_unit_pkg::*;
#(
  parameter int unsigned NR_SRC = WB_NR_SRC,
  parameter int unsigned NR_WB  = NR_WB_PORTS,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   flush_i,
  input  logic [NR_SRC-1:0]                      src_valid_i,
  output logic [NR_SRC-1:0]                      src_ready_o,
  input  logic [NR_SRC-1:0][TRANS_ID_BITS-1:0]   src_trans_id_i,
  input  logic [NR_SRC-1:0][XLEN-1:0]            src_result_i,
  input  exception_t [NR_SRC-1:0]                src_exception_i,
  output logic [NR_WB-1:0]                       wb_valid_o,
  output logic [NR_WB-1:0][TRANS_ID_BITS-1:0]    wb_trans_id_o,
  output logic [NR_WB-1:0][XLEN-1:0]             wb_result_o,
  output exception_t [NR_WB-1:0]                 wb_exception_o,
  output logic                                   overflow_o
);

  localparam int unsigned    PTR_W   = $clog2(DEPTH);
  localparam int unsigned    IDX_W   = idx_width(NR_SRC);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  wb_entry_t                   r_mem [NR_SRC][DEPTH];
  logic [NR_SRC-1:0][PTR_W:0]  r_wptr;
  logic [NR_SRC-1:0][PTR_W:0]  r_rptr;
  logic [IDX_W-1:0]            r_rr;
  logic                        r_overflow;

  logic [NR_SRC-1:0]           w_full;
  logic [NR_SRC-1:0]           w_empty;
  logic [NR_SRC-1:0]           w_push;
  logic [NR_SRC-1:0]           w_drop;
  logic [NR_SRC-1:0]           w_pop;
  wb_entry_t                   w_head [NR_SRC];
  logic [NR_WB-1:0][IDX_W-1:0] w_grant_idx;
  logic [NR_WB-1:0]            w_grant_valid;
  logic [IDX_W-1:0]            w_rr_next;

  // FIFO status: the extra wrap bit tells full from empty when indices match.
  always_comb begin
    for (int s = 0; s < NR_SRC; s++) begin
      w_empty[s] = (r_wptr[s] == r_rptr[s]);
      w_full[s]  = (r_wptr[s] == {~r_rptr[s][PTR_W], r_rptr[s][PTR_W-1:0]});
      w_head[s]  = r_mem[s][r_rptr[s][PTR_W-1:0]];
    end
  end

  // Ready only looks at occupancy, so arbitration never feeds back into it.
  assign src_ready_o = ~w_full;
  assign w_push      = src_valid_i & ~w_full & {NR_SRC{~flush_i}};
  assign w_drop      = src_valid_i &  w_full & {NR_SRC{~flush_i}};
  assign overflow_o  = r_overflow;

  wb_rr_select #(
    .NR_SRC (NR_SRC),
    .NR_WB  (NR_WB)
  ) u_rr_select (
    .nonempty_i    (~w_empty),
    .rr_i          (r_rr),
    .grant_idx_o   (w_grant_idx),
    .grant_valid_o (w_grant_valid),
    .pop_o         (w_pop),
    .rr_next_o     (w_rr_next)
  );

  // Writeback ports: granted FIFO heads; idle ports and flush cycles drive 0.
  always_comb begin
    wb_valid_o     = '0;
    wb_trans_id_o  = '0;
    wb_result_o    = '0;
    wb_exception_o = '0;
    for (int k = 0; k < NR_WB; k++) begin
      if (w_grant_valid[k] && !flush_i) begin
        wb_valid_o[k]     = 1'b1;
        wb_trans_id_o[k]  = w_head[w_grant_idx[k]].trans_id;
        wb_result_o[k]    = w_head[w_grant_idx[k]].result;
        wb_exception_o[k] = w_head[w_grant_idx[k]].ex;
      end else begin
        wb_valid_o[k] = 1'b0;
      end
    end
  end

  // Pointers, round-robin start and sticky overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_rr       <= '0;
      r_overflow <= 1'b0;
    end else if (flush_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_rr       <= '0;
      r_overflow <= r_overflow;
    end else begin
      for (int s = 0; s < NR_SRC; s++) begin
        if (w_push[s]) r_wptr[s] <= r_wptr[s] + PTR_ONE;
        if (w_pop[s])  r_rptr[s] <= r_rptr[s] + PTR_ONE;
      end
      if (|w_grant_valid) r_rr <= w_rr_next;
      if (|w_drop)        r_overflow <= 1'b1;
    end
  end

  // FIFO storage; contents are only observed behind valid pointers.
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < NR_SRC; s++) begin
      if (w_push[s]) begin
        r_mem[s][r_wptr[s][PTR_W-1:0]] <= '{trans_id: src_trans_id_i[s],
                                            result:   src_result_i[s],
                                            ex:       src_exception_i[s]};
      end
    end
  end

endmodule

// File: tb/tb_wb_merge_unit.sv
module tb_wb_merge_unit;
  import wb_merge_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main DUT: default configuration (5 sources, 2 ports, depth 2).
  logic                  flush;
  logic [4:0]            vld;
  logic [4:0][3:0]       ids;
  logic [4:0][31:0]      res;
  exception_t [4:0]      exs;
  logic [4:0]            rdy;
  logic [1:0]            wb_valid;
  logic [1:0][3:0]       wb_id;
  logic [1:0][31:0]      wb_res;
  exception_t [1:0]      wb_ex;
  logic                  ovf;

  // Second DUT: a single writeback port, used for the fill/overflow sequence.
  logic                  flush1;
  logic [4:0]            vld1;
  logic [4:0][3:0]       ids1;
  logic [4:0][31:0]      res1;
  exception_t [4:0]      exs1;
  logic [4:0]            rdy1;
  logic [0:0]            wb1_valid;
  logic [0:0][3:0]       wb1_id;
  logic [0:0][31:0]      wb1_res;
  exception_t [0:0]      wb1_ex;
  logic                  ovf1;

  wb_merge_unit u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .src_valid_i(vld), .src_ready_o(rdy), .src_trans_id_i(ids),
    .src_result_i(res), .src_exception_i(exs),
    .wb_valid_o(wb_valid), .wb_trans_id_o(wb_id), .wb_result_o(wb_res),
    .wb_exception_o(wb_ex), .overflow_o(ovf)
  );

  wb_merge_unit #(.NR_SRC(5), .NR_WB(1), .DEPTH(2)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush1),
    .src_valid_i(vld1), .src_ready_o(rdy1), .src_trans_id_i(ids1),
    .src_result_i(res1), .src_exception_i(exs1),
    .wb_valid_o(wb1_valid), .wb_trans_id_o(wb1_id), .wb_result_o(wb1_res),
    .wb_exception_o(wb1_ex), .overflow_o(ovf1)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Scoreboard: per-source queues of accepted entries, in push order.
  wb_entry_t sb_q [5][$];

  typedef struct {
    logic [4:0]  vld;
    logic [3:0]  id_base;
    logic [31:0] res_base;
    logic        flush;
    logic [1:0]  e_valid;
    logic [3:0]  e_id0;
    logic [3:0]  e_id1;
    logic [31:0] e_res0;
    logic [31:0] e_res1;
  } vec_t;
  vec_t tbl [11];

  logic [3:0] e1_id  [10];
  logic       e1_v   [10];
  logic [1:0] e1_rdy [10];
  logic       e1_ovf [10];

  function automatic wb_entry_t mk_entry(input logic [3:0] id, input logic [31:0] r);
    wb_entry_t e;
    e.trans_id = id;
    e.result   = r;
    e.ex.cause = {28'd0, id};
    e.ex.tval  = ~r;
    e.ex.valid = id[0];
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic clear_push();
    vld = '0; ids = '0; res = '0; exs = '0;
    vld1 = '0; ids1 = '0; res1 = '0; exs1 = '0;
  endtask

  task automatic set_push(input int s, input logic [3:0] id, input logic [31:0] r);
    wb_entry_t e;
    e = mk_entry(id, r);
    vld[s] = 1'b1; ids[s] = id; res[s] = r; exs[s] = e.ex;
  endtask

  task automatic set_push1(input int s, input logic [3:0] id, input logic [31:0] r);
    wb_entry_t e;
    e = mk_entry(id, r);
    vld1[s] = 1'b1; ids1[s] = id; res1[s] = r; exs1[s] = e.ex;
  endtask

  task automatic sb_clear();
    for (int s = 0; s < 5; s++) sb_q[s].delete();
  endtask

  // Pop/compare what the main DUT writes back, then record this cycle's pushes.
  task automatic sb_monitor();
    wb_entry_t got;
    bit found;
    for (int k = 0; k < 2; k++) begin
      if (wb_valid[k]) begin
        got = '{trans_id: wb_id[k], result: wb_res[k], ex: wb_ex[k]};
        found = 1'b0;
        for (int s = 0; s < 5; s++) begin
          if (!found && sb_q[s].size() > 0 && sb_q[s][0] == got) begin
            void'(sb_q[s].pop_front());
            found = 1'b1;
          end
        end
        n_cmp++;
        if (!found) begin
          n_fail++;
          $display("FAIL sb_match port%0d: got id=%0h res=%0h, expected an entry at the head of a source queue",
                   k, wb_id[k], wb_res[k]);
        end
      end
    end
    if (flush) begin
      chk("flush_wb_valid", 64'(wb_valid), 64'd0);
      sb_clear();
    end else begin
      for (int s = 0; s < 5; s++)
        if (vld[s] && rdy[s]) sb_q[s].push_back(mk_entry(ids[s], res[s]));
    end
  endtask

  task automatic to_negedge();
    @(negedge clk);
  endtask

  task automatic end_cycle();
    sb_monitor();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int total;
    rst_n = 1'b0; flush = 1'b0; flush1 = 1'b0;
    clear_push();

    tbl[0]  = '{5'b00001, 4'd3, 32'h0000DEAD, 1'b0, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0};
    tbl[1]  = '{5'b00000, 4'd0, 32'h0,        1'b0, 2'b01, 4'd3, 4'd0, 32'h0000DEAD, 32'd0};
    tbl[2]  = '{5'b00000, 4'd0, 32'h0,        1'b0, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0};
    tbl[3]  = '{5'b00000, 4'd0, 32'h0,        1'b1, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0};
    tbl[4]  = '{5'b11111, 4'd1, 32'h00001000, 1'b0, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0};
    tbl[5]  = '{5'b00000, 4'd0, 32'h0,        1'b0, 2'b11, 4'd1, 4'd2, 32'h1000, 32'h1001};
    tbl[6]  = '{5'b00000, 4'd0, 32'h0,        1'b0, 2'b11, 4'd3, 4'd4, 32'h1002, 32'h1003};
    tbl[7]  = '{5'b00000, 4'd0, 32'h0,        1'b0, 2'b01, 4'd5, 4'd0, 32'h1004, 32'd0};
    tbl[8]  = '{5'b00101, 4'd6, 32'h00002000, 1'b0, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0};
    tbl[9]  = '{5'b00000, 4'd0, 32'h0,        1'b0, 2'b11, 4'd6, 4'd8, 32'h2000, 32'h2002};
    tbl[10] = '{5'b00000, 4'd0, 32'h0,        1'b0, 2'b00, 4'd0, 4'd0, 32'd0, 32'd0};

    // Single-port DUT: flu and load push every cycle for 6 cycles.
    e1_id  = '{4'd0, 4'd0, 4'd8, 4'd1, 4'd9, 4'd2, 4'd11, 4'd4, 4'd13, 4'd0};
    e1_v   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    e1_rdy = '{2'b11, 2'b11, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b11, 2'b11, 2'b11};
    e1_ovf = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Idle after reset.
    for (int c = 0; c < 10; c++) begin
      to_negedge();
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_ready", 64'(rdy), 64'h1F);
      chk("rst_overflow", 64'(ovf), 64'd0);
      end_cycle();
    end

    // Table: single push, flush, five-way push, round-robin restart at 0.
    for (int i = 0; i < 11; i++) begin
      clear_push();
      flush = tbl[i].flush;
      for (int s = 0; s < 5; s++)
        if (tbl[i].vld[s]) set_push(s, tbl[i].id_base + 4'(s), tbl[i].res_base + 32'(s));
      to_negedge();
      chk("tbl_wb_valid", 64'(wb_valid), 64'(tbl[i].e_valid));
      chk("tbl_id0", 64'(wb_id[0]), 64'(tbl[i].e_id0));
      chk("tbl_id1", 64'(wb_id[1]), 64'(tbl[i].e_id1));
      chk("tbl_res0", 64'(wb_res[0]), 64'(tbl[i].e_res0));
      chk("tbl_res1", 64'(wb_res[1]), 64'(tbl[i].e_res1));
      chk("tbl_ready", 64'(rdy), 64'h1F);
      chk("tbl_overflow", 64'(ovf), 64'd0);
      end_cycle();
    end
    flush = 1'b0;
    clear_push();

    // Single-port DUT: alternating grants, load FIFO fills, sticky overflow.
    for (int c = 0; c < 10; c++) begin
      clear_push();
      if (c < 6) begin
        set_push1(0, 4'(c), 32'hC000_0000 | 32'(c));
        set_push1(1, 4'(8 + c), 32'hC000_0000 | 32'(8 + c));
      end
      to_negedge();
      chk("nwb1_valid", 64'(wb1_valid), 64'(e1_v[c]));
      chk("nwb1_id", 64'(wb1_id[0]), 64'(e1_id[c]));
      chk("nwb1_res", 64'(wb1_res[0]), e1_v[c] ? 64'(32'hC000_0000 | 32'(e1_id[c])) : 64'd0);
      chk("nwb1_ready", 64'(rdy1), 64'({3'b111, e1_rdy[c]}));
      chk("nwb1_overflow", 64'(ovf1), 64'(e1_ovf[c]));
      end_cycle();
    end
    clear_push();
    flush1 = 1'b1;
    to_negedge();
    chk("nwb1_flush_valid", 64'(wb1_valid), 64'd0);
    end_cycle();
    flush1 = 1'b0;
    to_negedge();
    chk("nwb1_ovf_after_flush", 64'(ovf1), 64'd1);
    end_cycle();

    // Flush with buffered entries and a concurrent push into a full FIFO.
    clear_push();
    for (int s = 0; s < 3; s++) set_push(s, 4'(s), 32'hF000_0000 + 32'(s));
    to_negedge(); end_cycle();
    clear_push();
    for (int s = 0; s < 3; s++) set_push(s, 4'(4 + s), 32'hF000_0000 + 32'(4 + s));
    to_negedge(); end_cycle();
    clear_push();
    set_push(0, 4'd8, 32'hF000_0008);
    set_push(1, 4'd9, 32'hF000_0009);
    to_negedge();
    chk("pre_flush_ready", 64'(rdy), 64'h1B);
    end_cycle();
    clear_push();
    flush = 1'b1;
    set_push(0, 4'd12, 32'hF000_000C);
    set_push(1, 4'd13, 32'hF000_000D);
    to_negedge();
    chk("flush_valid", 64'(wb_valid), 64'd0);
    chk("flush_full_ready", 64'(rdy), 64'h1D);
    end_cycle();
    flush = 1'b0;
    clear_push();
    set_push(0, 4'd1, 32'h0000_00A0);
    set_push(3, 4'd2, 32'h0000_00A3);
    to_negedge();
    chk("post_flush_valid", 64'(wb_valid), 64'd0);
    chk("post_flush_ready", 64'(rdy), 64'h1F);
    chk("post_flush_overflow", 64'(ovf), 64'd0);
    end_cycle();
    clear_push();
    to_negedge();
    chk("post_flush_rr_valid", 64'(wb_valid), 64'd3);
    chk("post_flush_rr_id0", 64'(wb_id[0]), 64'd1);
    chk("post_flush_rr_id1", 64'(wb_id[1]), 64'd2);
    end_cycle();
    for (int c = 0; c < 4; c++) begin
      to_negedge();
      chk("no_stale_valid", 64'(wb_valid), 64'd0);
      end_cycle();
    end

    // Asynchronous reset between clock edges while entries are buffered.
    for (int s = 0; s < 4; s++) set_push(s, 4'(1 + s), 32'h0000_00B0 + 32'(s));
    to_negedge(); end_cycle();
    clear_push();
    #2;
    chk("pre_rst_valid", 64'(wb_valid), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(wb_valid), 64'd0);
    chk("async_rst_id", 64'(wb_id), 64'd0);
    chk("async_rst_res", 64'(wb_res), 64'd0);
    chk("async_rst_ready", 64'(rdy), 64'h1F);
    chk("async_rst_ovf1", 64'(ovf1), 64'd0);
    sb_clear();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    set_push(2, 4'd7, 32'h0000_BEEF);
    to_negedge();
    chk("rst_nobypass_valid", 64'(wb_valid), 64'd0);
    end_cycle();
    clear_push();
    to_negedge();
    chk("rst_push_valid", 64'(wb_valid), 64'd1);
    chk("rst_push_id", 64'(wb_id[0]), 64'd7);
    chk("rst_push_res", 64'(wb_res[0]), 64'h0000_BEEF);
    end_cycle();

    // Drain and confirm every accepted entry was written back.
    for (int c = 0; c < 4; c++) begin
      to_negedge(); end_cycle();
    end
    total = 0;
    for (int s = 0; s < 5; s++) total += sb_q[s].size();
    chk("sb_drained", 64'(total), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
